commit_trace: RTL and testbench
===============================

COMMIT_TRACE -- requirements
Module: commit_trace

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter SEQ_W, default 16, meaning width of the sequence and drop counters.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port trace_en  input  1  capture enable.
REQ-006 SHALL have port flush  input  1  synchronous FIFO clear.
REQ-007 SHALL have port commit_valid  input  1  the CPU retires an instruction this cycle.
REQ-008 SHALL have port commit_we  input  1  the retired instruction writes the register file.
REQ-009 SHALL have port commit_pc  input  32  PC of the retired instruction.
REQ-010 SHALL have port commit_rd  input  5  destination register index.
REQ-011 SHALL have port commit_data  input  32  value written to rd.
REQ-012 SHALL have port trace_valid  output  1  head entry available.
REQ-013 SHALL have port trace_ready  input  1  consumer accepts the head entry.
REQ-014 SHALL have port trace_pc  output  32  head entry PC.
REQ-015 SHALL have port trace_rd  output  5  head entry rd.
REQ-016 SHALL have port trace_data  output  32  head entry data.
REQ-017 SHALL have port trace_seq  output  SEQ_W  head entry sequence number.
REQ-018 SHALL have port drop_count  output  SEQ_W  events lost to overflow.
REQ-019 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-020 SHALL treat an event as qualifying when trace_en && commit_valid && commit_we && commit_rd != 0 in the same cycle.
REQ-021 SHALL assign each qualifying event the current seq counter value and then increment the counter modulo 2^SEQ_W, whether or not the event is stored.
REQ-022 SHALL push a qualifying event when level < DEPTH, or when level == DEPTH and a pop occurs in the same cycle.
REQ-023 SHALL drop a qualifying event when level == DEPTH and no pop occurs, incrementing drop_count, which saturates at 2^SEQ_W-1.
REQ-024 SHALL make a pushed entry visible on the trace_* outputs no earlier than the next cycle (latency 1 from an empty FIFO).
REQ-025 SHALL pop the head entry on a cycle where trace_valid && trace_ready.
REQ-026 SHALL hold trace_valid high and keep trace_pc/rd/data/seq stable once trace_valid is asserted, until the entry is popped.
REQ-027 SHALL drive trace_valid = (level != 0), and SHALL drive trace_pc/rd/data/seq to zero while level == 0.
REQ-028 SHALL apply push and pop together in one cycle without changing level.
REQ-029 SHALL wrap read and write pointers modulo DEPTH.
REQ-030 SHALL, when flush is high, set level to 0 and discard all entries and any same-cycle push or pop; seq counter and drop_count are not affected.
REQ-031 SHALL ignore a non-qualifying commit, including an rd=x0 write, with no effect on any counter.

Reset
REQ-032 SHALL, on rst high, immediately clear the pointers, level, seq counter and drop_count, with trace_valid=0 and all trace_* outputs 0.
REQ-033 SHALL discard FIFO contents on a reset asserted mid-operation, and SHALL take the first qualifying event after reset release as seq 0.

Structure
REQ-034 SHALL place the entry record type (pc, rd, data, seq), the default DEPTH, and the field widths in shared package cpu_trace_pkg.
REQ-035 SHALL implement storage as one sub-module, sync_fifo, with push/pop/flush/full/empty/level; commit_trace adds qualification, sequencing and drop accounting.

Verification
REQ-036 SHALL verify this case: single commit pc=0x10, rd=1, data=0xA5, with trace_ready=1 -> trace_valid exactly one cycle later, showing pc 0x10, rd 1, data 0xA5, seq 0.
REQ-037 SHALL verify this case: commit to rd=0, then commit_we=0, then trace_en=0 -> no push, seq stays 0, level 0.
REQ-038 SHALL verify this case: trace_ready=0 and 10 qualifying commits with DEPTH=8 -> level 8, drop_count 2; after draining, seqs read 0..7; the next event has seq 10.
REQ-039 SHALL verify this case: FIFO full with simultaneous push and pop -> level remains 8, drop_count unchanged, and the new entry reaches the output 8 pops later.
REQ-040 SHALL verify this case: with trace_ready toggling every cycle, 20 events -> outputs stable while stalled, seqs 0..19 delivered in order, and no drops.
REQ-041 SHALL verify this case: rst asserted with level 5 and drop_count 3 -> outputs zero asynchronously, before the next clock edge; the next event gets seq 0; and flush with level 4 -> level 0 with seq continuing.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// Shared types and widths for the commit trace path.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package cpu_trace_pkg;

    localparam int TRACE_DEPTH = 8;
    localparam int PC_W        = 32;
    localparam int RD_W        = 5;
    localparam int DATA_W      = 32;
    localparam int SEQ_W_DEF   = 16;

    // Architectural part of a trace entry; the sequence number is appended by
    // commit_trace because its width is a per-instance parameter.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } commit_rec_t;

    function automatic logic commit_qualifies(input logic en, input logic vld,
                                              input logic we, input logic [RD_W-1:0] rd);
        return en && vld && we && (rd != '0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy count and synchronous flush.
// Latency: a pushed word is visible at pop_dat the cycle after the push.
// Backpressure: push is accepted when not full, or when full with a same-cycle pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LVL_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/commit_trace.sv
// Captures register-writing retirements into a trace FIFO with sequence numbers.
// Latency: one cycle from a qualifying commit to trace_valid on an empty FIFO.
// Backpressure: valid/ready on the trace side; events arriving at a full FIFO are dropped and counted.
module commit_trace
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH,
    parameter int SEQ_W = SEQ_W_DEF,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trace_en,
    input  logic              flush,
    input  logic              commit_valid,
    input  logic              commit_we,
    input  logic [PC_W-1:0]   commit_pc,
    input  logic [RD_W-1:0]   commit_rd,
    input  logic [DATA_W-1:0] commit_data,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [PC_W-1:0]   trace_pc,
    output logic [RD_W-1:0]   trace_rd,
    output logic [DATA_W-1:0] trace_data,
    output logic [SEQ_W-1:0]  trace_seq,
    output logic [SEQ_W-1:0]  drop_count,
    output logic [LVL_W-1:0]  level
);

    typedef struct packed {
        commit_rec_t      rec;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    entry_t           wr_ent;
    entry_t           head;
    logic [SEQ_W-1:0] seq_q;
    logic             qual;
    logic             pop;
    logic             push;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;

    assign qual = commit_qualifies(trace_en, commit_valid, commit_we, commit_rd);
    assign pop  = trace_valid && trace_ready;
    assign push = qual && (!fifo_full || pop);
    assign drop = qual && fifo_full && !pop;

    assign wr_ent.rec.pc   = commit_pc;
    assign wr_ent.rec.rd   = commit_rd;
    assign wr_ent.rec.data = commit_data;
    assign wr_ent.seq      = seq_q;

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (push),
        .push_dat (wr_ent),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    // Storage is not reset, so the head is masked whenever the FIFO is empty.
    assign trace_valid = !fifo_empty;
    assign trace_pc    = trace_valid ? head.rec.pc   : '0;
    assign trace_rd    = trace_valid ? head.rec.rd   : '0;
    assign trace_data  = trace_valid ? head.rec.data : '0;
    assign trace_seq   = trace_valid ? head.seq      : '0;

    // Every qualifying event consumes a sequence number, stored or dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q      <= '0;
            drop_count <= '0;
        end else begin
            if (qual) seq_q <= seq_q + 1'b1;
            if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_commit_trace.sv
// Directed bench for commit_trace with hand-computed expectations.
module tb_commit_trace;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_en;
    logic        flush;
    logic        commit_valid;
    logic        commit_we;
    logic [31:0] commit_pc;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_rd;
    logic [31:0] trace_data;
    logic [15:0] trace_seq;
    logic [15:0] drop_count;
    logic [3:0]  level;

    int n_cmp = 0;
    int n_bad = 0;

    commit_trace dut (
        .clk          (clk),
        .rst          (rst),
        .trace_en     (trace_en),
        .flush        (flush),
        .commit_valid (commit_valid),
        .commit_we    (commit_we),
        .commit_pc    (commit_pc),
        .commit_rd    (commit_rd),
        .commit_data  (commit_data),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_pc     (trace_pc),
        .trace_rd     (trace_rd),
        .trace_data   (trace_data),
        .trace_seq    (trace_seq),
        .drop_count   (drop_count),
        .level        (level)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_commit(input logic en, input logic vld, input logic we,
                              input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] d);
        trace_en     = en;
        commit_valid = vld;
        commit_we    = we;
        commit_pc    = pc;
        commit_rd    = rd;
        commit_data  = d;
    endtask

    task automatic idle;
        set_commit(1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
    endtask

    task automatic do_reset;
        idle();
        flush       = 1'b0;
        trace_ready = 1'b0;
        rst         = 1'b1;
        #2;
        rst         = 1'b0;
        step();
    endtask

    task automatic push_events(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            set_commit(1'b1, 1'b1, 1'b1, base + 32'(i * 4), 5'(i % 31 + 1), 32'(i));
            step();
        end
        idle();
    endtask

    initial begin
        logic [31:0] held_pc;
        logic [15:0] held_seq;
        logic        stall_prev;
        int          sent;
        int          recv;

        rst = 1'b1;
        idle();
        flush       = 1'b0;
        trace_ready = 1'b0;
        #1;
        check_eq("rst_valid", trace_valid, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_drop",  drop_count, 0);
        check_eq("rst_pc",    trace_pc, 0);
        #3 rst = 1'b0;
        step();

        // Non-qualifying commits: rd=x0, no write, capture disabled.
        set_commit(1'b1, 1'b1, 1'b1, 32'h40, 5'd0, 32'h1);  step();
        set_commit(1'b1, 1'b1, 1'b0, 32'h44, 5'd3, 32'h2);  step();
        set_commit(1'b0, 1'b1, 1'b1, 32'h48, 5'd4, 32'h3);  step();
        idle();
        step();
        check_eq("nq_level", level, 0);
        check_eq("nq_valid", trace_valid, 0);

        // Single commit, latency one.
        trace_ready = 1'b1;
        set_commit(1'b1, 1'b1, 1'b1, 32'h10, 5'd1, 32'hA5);
        check_eq("one_pre_valid", trace_valid, 0);
        step();
        idle();
        check_eq("one_valid", trace_valid, 1);
        check_eq("one_pc",    trace_pc, 32'h10);
        check_eq("one_rd",    trace_rd, 1);
        check_eq("one_data",  trace_data, 32'hA5);
        check_eq("one_seq",   trace_seq, 0);
        step();
        check_eq("one_popped", trace_valid, 0);

        // Overflow: 10 events into 8 entries.
        do_reset();
        push_events(10, 32'h100);
        check_eq("ovf_level", level, 8);
        check_eq("ovf_drop",  drop_count, 2);
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("ovf_seq", trace_seq, 64'(i));
            check_eq("ovf_pc",  trace_pc, 64'(32'h100 + i * 4));
            step();
        end
        trace_ready = 1'b0;
        check_eq("ovf_empty", level, 0);
        push_events(1, 32'h300);
        check_eq("ovf_next_seq", trace_seq, 10);
        trace_ready = 1'b1;
        step();
        trace_ready = 1'b0;

        // Full FIFO with simultaneous push and pop; seqs 11..18 fill it.
        push_events(8, 32'h400);
        check_eq("fpp_full", level, 8);
        trace_ready = 1'b1;
        set_commit(1'b1, 1'b1, 1'b1, 32'hBEEF0, 5'd3, 32'h55);
        step();
        idle();
        trace_ready = 1'b0;
        check_eq("fpp_level", level, 8);
        check_eq("fpp_drop",  drop_count, 2);
        check_eq("fpp_head",  trace_seq, 12);
        trace_ready = 1'b1;
        repeat (7) step();
        trace_ready = 1'b0;
        check_eq("fpp_new_pc",  trace_pc, 32'hBEEF0);
        check_eq("fpp_new_seq", trace_seq, 19);
        check_eq("fpp_level1",  level, 1);

        // Ready toggling every cycle, events on two of every three cycles.
        do_reset();
        sent = 0;
        recv = 0;
        stall_prev = 1'b0;
        held_pc = '0;
        held_seq = '0;
        for (int cyc = 0; cyc < 300 && recv < 20; cyc++) begin
            if (stall_prev) begin
                check_eq("tog_hold_vld", trace_valid, 1);
                check_eq("tog_hold_pc",  trace_pc, held_pc);
                check_eq("tog_hold_seq", trace_seq, held_seq);
            end
            trace_ready = cyc[0];
            if ((cyc % 3 != 2) && sent < 20) begin
                set_commit(1'b1, 1'b1, 1'b1, 32'h2000 + 32'(sent * 4), 5'd5, ~32'(sent));
                sent++;
            end else begin
                idle();
            end
            if (trace_valid && trace_ready) begin
                check_eq("tog_seq", trace_seq, 64'(recv));
                check_eq("tog_pc",  trace_pc, 64'(32'h2000 + recv * 4));
                recv++;
            end
            stall_prev = trace_valid && !trace_ready;
            held_pc    = trace_pc;
            held_seq   = trace_seq;
            step();
        end
        idle();
        trace_ready = 1'b0;
        check_eq("tog_count", recv, 20);
        check_eq("tog_drop",  drop_count, 0);

        // Asynchronous reset mid-operation with level 5 and drop_count 3.
        do_reset();
        push_events(11, 32'h600);
        check_eq("ar_pre_drop", drop_count, 3);
        trace_ready = 1'b1;
        repeat (3) step();
        trace_ready = 1'b0;
        check_eq("ar_pre_level", level, 5);
        rst = 1'b1;
        #1;
        check_eq("ar_valid", trace_valid, 0);
        check_eq("ar_level", level, 0);
        check_eq("ar_drop",  drop_count, 0);
        check_eq("ar_pc",    trace_pc, 0);
        check_eq("ar_seq",   trace_seq, 0);
        rst = 1'b0;
        push_events(1, 32'h700);
        check_eq("ar_first_seq", trace_seq, 0);
        push_events(3, 32'h800);
        check_eq("fl_pre_level", level, 4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("fl_level", level, 0);
        check_eq("fl_valid", trace_valid, 0);
        push_events(1, 32'h900);
        check_eq("fl_next_seq", trace_seq, 4);
        check_eq("fl_drop",     drop_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
